// File: rtl/n64_pkg.sv
// Shared constants and state encoding for the N64 poll scheduler.
// Bit positions follow the transceiver report layout.
package n64_pkg;

  localparam int unsigned RPT_W = 30;
  localparam int unsigned BTN_W = 14;
  localparam int unsigned DIR_W = 4;

  localparam int unsigned BTN_A      = 29;
  localparam int unsigned BTN_B      = 28;
  localparam int unsigned BTN_Z      = 27;
  localparam int unsigned BTN_START  = 26;
  localparam int unsigned DPAD_U     = 25;
  localparam int unsigned DPAD_D     = 24;
  localparam int unsigned DPAD_L     = 23;
  localparam int unsigned DPAD_R     = 22;
  localparam int unsigned BTN_L      = 21;
  localparam int unsigned BTN_R      = 20;
  localparam int unsigned C_U        = 19;
  localparam int unsigned C_D        = 18;
  localparam int unsigned C_L        = 17;
  localparam int unsigned C_R        = 16;
  localparam int unsigned STICK_X_HI = 15;
  localparam int unsigned STICK_Y_HI = 7;

  localparam int unsigned DIR_U = 3;
  localparam int unsigned DIR_D = 2;
  localparam int unsigned DIR_L = 1;
  localparam int unsigned DIR_R = 0;

  typedef enum logic [1:0] {
    StIdle,
    StWaitTick,
    StIssue,
    StWaitResp
  } poll_state_e;

endpackage

// File: rtl/n64_poll_scheduler_if.sv
// Bundle between the transceiver/game side and the poll scheduler.
// The scheduler uses the master modport; its environment uses slave.
interface n64_poll_scheduler_if;

  logic                        enable;
  logic                        busy;
  logic                        rx_valid;
  logic [n64_pkg::RPT_W-1:0]   rx_data;
  logic                        rx_timeout;
  logic                        poll_req;
  logic [n64_pkg::RPT_W-1:0]   buttons;
  logic [n64_pkg::BTN_W-1:0]   pressed;
  logic [n64_pkg::DIR_W-1:0]   stick_dir;
  logic                        connected;
  logic [7:0]                  err_count;

  modport master (
    input  enable, busy, rx_valid, rx_data, rx_timeout,
    output poll_req, buttons, pressed, stick_dir, connected, err_count
  );

  modport slave (
    output enable, busy, rx_valid, rx_data, rx_timeout,
    input  poll_req, buttons, pressed, stick_dir, connected, err_count
  );

endinterface

// File: rtl/n64_stick_dir.sv
// Quantizes the joystick into four directions and pulses newly active ones.
// Uses 9-bit signed compares so that -128 stays below the negative threshold.
module n64_stick_dir
  import n64_pkg::*;
#(
  parameter int unsigned DeadZone = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_x,
  input  logic [7:0]       i_y,
  input  logic             i_upd,
  input  logic             i_clr,
  output logic [DIR_W-1:0] o_dir
);

  localparam logic signed [8:0] Dz = 9'(DeadZone);

  logic signed [8:0] w_x;
  logic signed [8:0] w_y;
  logic [DIR_W-1:0]  w_act;
  logic [DIR_W-1:0]  r_prev;
  logic [DIR_W-1:0]  r_dir;

  always_comb begin
    w_x          = {i_x[7], i_x};
    w_y          = {i_y[7], i_y};
    w_act        = '0;
    w_act[DIR_U] = w_y > Dz;
    w_act[DIR_D] = w_y < -Dz;
    w_act[DIR_L] = w_x < -Dz;
    w_act[DIR_R] = w_x > Dz;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= '0;
      r_dir  <= '0;
    end else if (i_clr) begin
      r_prev <= '0;
      r_dir  <= '0;
    end else if (i_upd) begin
      r_dir  <= w_act & ~r_prev;
      r_prev <= w_act;
    end else begin
      r_dir  <= '0;
    end
  end

  assign o_dir = r_dir;

endmodule

// File: rtl/n64_poll_scheduler.sv
// Paces N64 controller polls, supervises each transaction with a watchdog
// and miss counter, and turns good reports into buttons and edge pulses.
module n64_poll_scheduler
  import n64_pkg::*;
#(
  parameter int unsigned ClockFreq = 27000000,
  parameter int unsigned PollRate  = 60,
  parameter int unsigned RespTo    = 27000,
  parameter int unsigned MaxMiss   = 3,
  parameter int unsigned DeadZone  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  n64_poll_scheduler_if.master io_bus
);

  localparam int unsigned     Period  = ClockFreq / PollRate;
  localparam int unsigned     PerW    = $clog2(Period + 1);
  localparam int unsigned     WdW     = $clog2(RespTo + 1);
  localparam logic [PerW-1:0] PerLast = PerW'(Period - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(RespTo - 1);
  localparam logic [3:0]      MissMax = 4'(MaxMiss);

  poll_state_e      r_state;
  poll_state_e      w_state_next;
  logic [PerW-1:0]  r_per;
  logic [WdW-1:0]   r_wd;
  logic [3:0]       r_miss;
  logic [3:0]       w_miss_inc;
  logic [7:0]       r_err;
  logic             r_conn;
  logic [RPT_W-1:0] r_btn;
  logic [BTN_W-1:0] r_pressed;
  logic [DIR_W-1:0] w_dir;
  logic             w_poll;
  logic             w_good;
  logic             w_fail;
  logic             w_lost;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (io_bus.enable) w_state_next = StIssue;
      StIssue:    if (!io_bus.busy) w_state_next = StWaitResp;
      StWaitResp: if (w_good || w_fail) w_state_next = StWaitTick;
      StWaitTick: if (r_per >= PerLast) w_state_next = io_bus.enable ? StIssue : StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // RxValid beats RxTimeout when both arrive together.
  always_comb begin
    w_poll = (r_state == StIssue) && !io_bus.busy;
    w_good = (r_state == StWaitResp) && io_bus.rx_valid;
    w_fail = (r_state == StWaitResp) && !io_bus.rx_valid &&
             (io_bus.rx_timeout || (r_wd >= WdLast));
  end

  assign w_miss_inc = (r_miss >= MissMax) ? MissMax : r_miss + 4'd1;
  assign w_lost     = w_fail && (w_miss_inc == MissMax);

  // The period counter holds cycles elapsed since the PollReq cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_per <= '0;
      r_wd  <= '0;
    end else if (w_poll) begin
      r_per <= (PerLast == '0) ? '0 : PerW'(1);
      r_wd  <= '0;
    end else begin
      if (r_per < PerLast) r_per <= r_per + 1'b1;
      if (r_wd < WdLast)   r_wd  <= r_wd + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_btn     <= '0;
      r_pressed <= '0;
      r_miss    <= '0;
      r_err     <= '0;
      r_conn    <= 1'b0;
    end else begin
      r_pressed <= '0;
      if (w_good) begin
        r_btn     <= io_bus.rx_data;
        r_pressed <= io_bus.rx_data[BTN_A:C_R] & ~r_btn[BTN_A:C_R];
        r_miss    <= '0;
        r_conn    <= 1'b1;
      end else if (w_fail) begin
        r_miss <= w_miss_inc;
        if (r_err != 8'hFF) r_err <= r_err + 8'd1;
        if (w_lost) begin
          r_conn <= 1'b0;
          r_btn  <= '0;
        end
      end
    end
  end

  n64_stick_dir #(
    .DeadZone (DeadZone)
  ) u_stick_dir (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_x   (io_bus.rx_data[STICK_X_HI -: 8]),
    .i_y   (io_bus.rx_data[STICK_Y_HI -: 8]),
    .i_upd (w_good),
    .i_clr (w_lost),
    .o_dir (w_dir)
  );

  assign io_bus.poll_req  = w_poll;
  assign io_bus.buttons   = r_btn;
  assign io_bus.pressed   = r_pressed;
  assign io_bus.stick_dir = w_dir;
  assign io_bus.connected = r_conn;
  assign io_bus.err_count = r_err;

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Scoreboard bench for n64_poll_scheduler: a transceiver model answers each
// poll, a reference model pushes expected outputs, the response is checked.
module tb_n64_poll_scheduler;
  import n64_pkg::*;

  localparam int ClockFreq = 1000;
  localparam int PollRate  = 100;
  localparam int RespTo    = 20;
  localparam int MaxMiss   = 3;
  localparam int DeadZone  = 16;
  localparam int Period    = ClockFreq / PollRate;

  typedef enum int {KValid, KTimeout, KNone, KBoth} kind_e;

  typedef struct {
    kind_e       kind;
    int          dly;
    logic [29:0] data;
    int          busy_hold;
    bit          stray;
    bit          drop_en;
  } poll_t;

  typedef struct packed {
    logic [29:0] btn;
    logic [13:0] prs;
    logic [3:0]  dir;
    logic        conn;
    logic [7:0]  err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   next_exp = 0;
  bit   have_exp = 0;

  logic [29:0] m_btn;
  logic [3:0]  m_prev;
  int          m_miss;
  int          m_err;
  logic        m_conn;
  exp_t        sb[$];
  poll_t       plan[$];

  n64_poll_scheduler_if bus ();

  n64_poll_scheduler #(
    .ClockFreq (ClockFreq),
    .PollRate  (PollRate),
    .RespTo    (RespTo),
    .MaxMiss   (MaxMiss),
    .DeadZone  (DeadZone)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_dir(input logic [29:0] d);
    int x;
    int y;
    logic [7:0] xb;
    logic [7:0] yb;
    xb = d[15:8];
    yb = d[7:0];
    x  = xb[7] ? int'(xb) - 256 : int'(xb);
    y  = yb[7] ? int'(yb) - 256 : int'(yb);
    return {y > DeadZone, y < -DeadZone, x < -DeadZone, x > DeadZone};
  endfunction

  task automatic model_reset();
    m_btn  = '0;
    m_prev = '0;
    m_miss = 0;
    m_err  = 0;
    m_conn = 1'b0;
  endtask

  task automatic model_good(input logic [29:0] d);
    exp_t e;
    logic [3:0] act;
    act    = ref_dir(d);
    e.prs  = d[29:16] & ~m_btn[29:16];
    e.dir  = act & ~m_prev;
    m_prev = act;
    m_btn  = d;
    m_miss = 0;
    m_conn = 1'b1;
    e.btn  = m_btn;
    e.conn = m_conn;
    e.err  = 8'(m_err);
    sb.push_back(e);
  endtask

  task automatic model_fail();
    exp_t e;
    m_err  = (m_err < 255) ? m_err + 1 : 255;
    m_miss = (m_miss < MaxMiss) ? m_miss + 1 : MaxMiss;
    if (m_miss == MaxMiss) begin
      m_conn = 1'b0;
      m_btn  = '0;
      m_prev = '0;
    end
    e.btn  = m_btn;
    e.prs  = '0;
    e.dir  = '0;
    e.conn = m_conn;
    e.err  = 8'(m_err);
    sb.push_back(e);
  endtask

  task automatic compare_out(input int idx);
    exp_t e;
    e = sb.pop_front();
    chk($sformatf("p%0d_buttons", idx), 32'(bus.buttons), 32'(e.btn));
    chk($sformatf("p%0d_pressed", idx), 32'(bus.pressed), 32'(e.prs));
    chk($sformatf("p%0d_stickdir", idx), 32'(bus.stick_dir), 32'(e.dir));
    chk($sformatf("p%0d_connected", idx), 32'(bus.connected), 32'(e.conn));
    chk($sformatf("p%0d_errcount", idx), 32'(bus.err_count), 32'(e.err));
  endtask

  // Starts at a negedge; returns the cycle index of the next PollReq.
  task automatic wait_poll(output int t, output bit seen);
    seen = 0;
    t    = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.poll_req) begin
        seen = 1;
        t    = cyc - base + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_poll(input int idx, input poll_t p);
    int t;
    int d;
    bit seen;
    if (p.busy_hold > 0) begin
      @(posedge clk);
      #1 bus.busy = 1'b1;
      while ((cyc - base + 1) < next_exp + p.busy_hold) begin
        @(posedge clk);
        #1;
      end
      bus.busy = 1'b0;
      @(negedge clk);
    end
    wait_poll(t, seen);
    chk($sformatf("p%0d_poll_seen", idx), 32'(seen), 32'd1);
    if (!seen) return;
    if (have_exp) chk($sformatf("p%0d_poll_cycle", idx), 32'(t), 32'(next_exp + p.busy_hold));
    if (p.drop_en) bus.enable = 1'b0;
    d = (p.kind == KNone) ? RespTo : p.dly;
    repeat (d) @(posedge clk);
    #1;
    if (p.kind != KNone) begin
      bus.rx_data    = p.data;
      bus.rx_valid   = (p.kind == KValid) || (p.kind == KBoth);
      bus.rx_timeout = (p.kind == KTimeout) || (p.kind == KBoth);
    end
    if ((p.kind == KValid) || (p.kind == KBoth)) model_good(p.data);
    else                                         model_fail();
    @(posedge clk);
    #1;
    bus.rx_valid   = 1'b0;
    bus.rx_timeout = 1'b0;
    @(negedge clk);
    compare_out(idx);
    @(negedge clk);
    chk($sformatf("p%0d_pressed_gone", idx), 32'(bus.pressed), 32'd0);
    chk($sformatf("p%0d_dir_gone", idx), 32'(bus.stick_dir), 32'd0);
    next_exp = t + ((Period > d + 2) ? Period : d + 2);
    have_exp = 1;
    if (p.stray) begin
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 30'h15555555;
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("p%0d_stray_btn", idx), 32'(bus.buttons), 32'(m_btn));
      chk($sformatf("p%0d_stray_prs", idx), 32'(bus.pressed), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    int polls;
    int idx;
    bus.enable     = 1'b1;
    bus.busy       = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_timeout = 1'b0;
    bus.rx_data    = '0;
    model_reset();

    plan.push_back('{KValid,   1,  30'h00000000, 0, 0, 0});
    plan.push_back('{KValid,   1,  30'h20000000, 0, 1, 0});
    plan.push_back('{KValid,   1,  30'h20000000, 0, 0, 0});
    plan.push_back('{KValid,   1,  30'h20001100, 0, 0, 0});
    plan.push_back('{KValid,   1,  30'h20008000, 0, 0, 0});
    plan.push_back('{KValid,   1,  30'h20001000, 5, 0, 0});
    plan.push_back('{KValid,   1,  30'h0A5A007F, 0, 0, 0});
    plan.push_back('{KValid,   1,  30'h0A5A0081, 0, 0, 0});
    plan.push_back('{KNone,    0,  30'h00000000, 0, 0, 0});
    plan.push_back('{KNone,    0,  30'h00000000, 0, 0, 0});
    plan.push_back('{KNone,    0,  30'h00000000, 0, 0, 0});
    plan.push_back('{KValid,   2,  30'h2A5A0000, 0, 0, 0});
    plan.push_back('{KBoth,    1,  30'h2A5A0000, 0, 0, 0});
    plan.push_back('{KTimeout, 5,  30'h00000000, 0, 0, 0});
    plan.push_back('{KValid,   15, 30'h00000000, 0, 0, 0});
    plan.push_back('{KValid,   1,  30'h10000000, 0, 0, 0});
    plan.push_back('{KValid,   3,  30'h00400000, 0, 0, 1});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pollreq", 32'(bus.poll_req), 32'd0);
    chk("rst_buttons", 32'(bus.buttons), 32'd0);
    chk("rst_connected", 32'(bus.connected), 32'd0);
    chk("rst_errcount", 32'(bus.err_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    base     = cyc;
    next_exp = 2;
    have_exp = 1;

    idx = 0;
    foreach (plan[i]) begin
      run_poll(idx, plan[i]);
      idx++;
    end

    // Enable was dropped mid-transaction: no further polls.
    polls = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.poll_req) polls++;
    end
    chk("no_poll_after_disable", 32'(polls), 32'd0);

    @(posedge clk);
    #1 bus.enable = 1'b1;
    @(negedge clk);
    next_exp = cyc - base + 2;
    begin
      int t;
      bit seen;
      wait_poll(t, seen);
      chk("reen_poll_cycle", 32'(t), 32'(next_exp));
    end

    // Reset while the transaction is outstanding.
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_pollreq", 32'(bus.poll_req), 32'd0);
    chk("arst_buttons", 32'(bus.buttons), 32'd0);
    chk("arst_connected", 32'(bus.connected), 32'd0);
    chk("arst_errcount", 32'(bus.err_count), 32'd0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 30'h3FFFFFFF;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.enable   = 1'b0;
    @(negedge clk);
    chk("arst_rx_ignored", 32'(bus.buttons), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    polls = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.poll_req) polls++;
    end
    chk("idle_after_rst", 32'(polls), 32'd0);
    chk("idle_connected", 32'(bus.connected), 32'd0);

    @(posedge clk);
    #1 bus.enable = 1'b1;
    next_exp = cyc - base + 2;
    have_exp = 1;
    @(negedge clk);
    run_poll(idx, '{KValid, 1, 30'h20000000, 0, 0, 0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
